// File: rtl/text_buffer_ctrl_if.sv
// Bus bundle between the text buffer, the glyph drawer, the font ROM and the character writer.
interface text_buffer_ctrl_if;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  cursor_xy;
  logic        busy;

  modport slave (
    input  char_xy, char_line, font_data, wr_data, wr_valid,
    output char_pixels, font_addr, wr_ready, cursor_xy, busy
  );

  modport master (
    output char_xy, char_line, font_data, wr_data, wr_valid,
    input  char_pixels, font_addr, wr_ready, cursor_xy, busy
  );
endinterface

// File: rtl/text_buffer_ctrl.sv
// 8x32 text-mode character buffer: writer cursor/control decoding, clear sequencer
// and a registered glyph lookup path with an optional underline cursor.
module text_buffer_ctrl #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter bit         CURSOR_EN  = 1'b1
) (
  input logic               pclk,
  input logic               rst,
  text_buffer_ctrl_if.slave bus
);
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [6:0] cells [0:255];
  logic [0:0] state, state_nxt;
  logic [7:0] clr_cnt, clr_cnt_nxt;
  logic [7:0] cursor, cursor_nxt;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [6:0] wr_val;
  logic [6:0] cell_code;
  logic       accept;
  logic       on_cursor;

  assign accept        = (state == ST_IDLE) && bus.wr_valid;
  assign cell_code     = cells[bus.char_xy];
  assign bus.font_addr = {cell_code, bus.char_line};
  assign bus.wr_ready  = (state == ST_IDLE);
  assign bus.busy      = (state == ST_CLEAR);
  assign bus.cursor_xy = cursor;
  assign on_cursor     = CURSOR_EN && (bus.char_xy == cursor) && (bus.char_line == 4'hF);

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    cursor_nxt  = cursor;
    wr_en       = 1'b0;
    wr_addr     = cursor;
    wr_val      = bus.wr_data[6:0];
    if (state == ST_CLEAR) begin
      wr_en       = 1'b1;
      wr_addr     = clr_cnt;
      wr_val      = CLEAR_CHAR[6:0];
      clr_cnt_nxt = clr_cnt + 8'd1;
      if (clr_cnt == 8'hFF) begin
        state_nxt  = ST_IDLE;
        cursor_nxt = 8'h00;
      end
    end else if (accept) begin
      case (bus.wr_data)
        8'h0D: cursor_nxt = {cursor[7:5], 5'd0};
        8'h0A: cursor_nxt = {cursor[7:5] + 3'd1, cursor[4:0]};
        8'h08: begin
          // Backspace blanks the cell it moves onto, in the same cycle.
          cursor_nxt = cursor - 8'd1;
          wr_en      = 1'b1;
          wr_addr    = cursor - 8'd1;
          wr_val     = CLEAR_CHAR[6:0];
        end
        8'h0C: begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = 8'h00;
        end
        default: begin
          if ((bus.wr_data >= 8'h20) && (bus.wr_data <= 8'h7E)) begin
            wr_en      = 1'b1;
            wr_addr    = cursor;
            wr_val     = bus.wr_data[6:0];
            cursor_nxt = cursor + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= 8'h00;
      cursor  <= 8'h00;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      cursor  <= cursor_nxt;
    end
  end

  // Cell storage is not reset; the clear sequence after reset initialises it.
  always_ff @(posedge pclk) begin
    if (wr_en && !rst) begin
      cells[wr_addr] <= wr_val;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      bus.char_pixels <= 8'h00;
    end else begin
      bus.char_pixels <= on_cursor ? 8'hFF : bus.font_data;
    end
  end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed scoreboard bench for text_buffer_ctrl: clear timing, writer codes,
// cursor wrap, same-cycle read-before-write, underline cursor and reset mid-clear.
module tb_text_buffer_ctrl;
  localparam logic [7:0] CLEAR_CHAR = 8'h20;

  logic pclk;
  logic rst;
  text_buffer_ctrl_if bus ();

  text_buffer_ctrl #(
    .CLEAR_CHAR(CLEAR_CHAR),
    .CURSOR_EN (1'b1)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_mem [0:255];
  logic [7:0] exp_cursor;
  logic [7:0] exp_q [$];

  // Stand-in font ROM: any fixed function of the address that separates codes and lines.
  function automatic logic [7:0] rom(input logic [10:0] a);
    return a[7:0] ^ {1'b0, a[10:4]};
  endfunction

  assign bus.font_data = rom(bus.font_addr);

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] glyph_model(input logic [7:0] xy, input logic [3:0] line);
    if (xy == exp_cursor && line == 4'hF) return 8'hFF;
    return rom({exp_mem[xy], line});
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic model_write(input logic [7:0] code);
    if (code >= 8'h20 && code <= 8'h7E) begin
      exp_mem[exp_cursor] = code[6:0];
      exp_cursor          = exp_cursor + 8'd1;
    end else if (code == 8'h0D) begin
      exp_cursor[4:0] = 5'd0;
    end else if (code == 8'h0A) begin
      exp_cursor[7:5] = exp_cursor[7:5] + 3'd1;
    end else if (code == 8'h08) begin
      exp_cursor          = exp_cursor - 8'd1;
      exp_mem[exp_cursor] = CLEAR_CHAR[6:0];
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] code);
    check_output("wr_ready_before_write", bus.wr_ready, 1);
    bus.wr_data  = code;
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    model_write(code);
    check_output("cursor_after_write", bus.cursor_xy, exp_cursor);
  endtask

  task automatic probe(input string tag, input logic [7:0] xy, input logic [3:0] line);
    bus.char_xy   = xy;
    bus.char_line = line;
    #1;
    check_output({tag, "_font_addr"}, bus.font_addr, {exp_mem[xy], line});
    exp_q.push_back(glyph_model(xy, line));
    tick();
    check_output({tag, "_queue"}, exp_q.size(), 1);
    check_output({tag, "_pixels"}, bus.char_pixels, exp_q.pop_front());
  endtask

  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (bus.busy === 1'b1 && cnt < 400) begin
      check_output({tag, "_ready_low"}, bus.wr_ready, 0);
      cnt++;
      tick();
    end
    for (int i = 0; i < 256; i++) exp_mem[i] = CLEAR_CHAR[6:0];
    exp_cursor = 8'h00;
    check_output({tag, "_busy_cycles"}, cnt, 256);
    check_output({tag, "_ready"}, bus.wr_ready, 1);
    check_output({tag, "_cursor"}, bus.cursor_xy, 8'h00);
  endtask

  initial begin
    rst           = 1'b1;
    bus.char_xy   = 8'h00;
    bus.char_line = 4'h0;
    bus.wr_data   = 8'h00;
    bus.wr_valid  = 1'b0;
    exp_cursor    = 8'h00;
    repeat (3) tick();
    check_output("reset_pixels", bus.char_pixels, 8'h00);
    check_output("reset_busy", bus.busy, 1);
    check_output("reset_ready", bus.wr_ready, 0);
    check_output("reset_cursor", bus.cursor_xy, 8'h00);
    rst = 1'b0;
    wait_clear("init_clear");

    for (int i = 0; i < 256; i++) begin
      bus.char_xy = 8'(i);
      #1;
      check_output("cleared_cell", bus.font_addr[10:4], CLEAR_CHAR[6:0]);
    end
    tick();

    // 'A' at cell 0, then its glyph row 5 one edge later
    apply_stimulus(8'h41);
    check_output("cursor_after_A", bus.cursor_xy, 8'h01);
    bus.char_xy   = 8'h00;
    bus.char_line = 4'h5;
    #1;
    check_output("font_addr_A5", bus.font_addr, 11'h415);
    probe("glyph_A5", 8'h00, 4'h5);

    probe("cursor_line15", exp_cursor, 4'hF);
    probe("cursor_line14", exp_cursor, 4'hE);

    // Same-cycle read of the cell being written returns the old code
    bus.char_xy   = exp_cursor;
    bus.char_line = 4'h3;
    bus.wr_data   = 8'h41;
    bus.wr_valid  = 1'b1;
    #1;
    exp_q.push_back(glyph_model(exp_cursor, 4'h3));
    tick();
    bus.wr_valid = 1'b0;
    check_output("rbw_pixels", bus.char_pixels, exp_q.pop_front());
    model_write(8'h41);
    probe("rbw_new", 8'h01, 4'h3);

    apply_stimulus(8'h07);
    apply_stimulus(8'h7F);
    apply_stimulus(8'hC1);
    apply_stimulus(8'h00);
    check_output("ignored_cursor", bus.cursor_xy, 8'h02);
    probe("ignored_cell", 8'h02, 4'h6);

    apply_stimulus(8'h0D);
    apply_stimulus(8'h0A);
    apply_stimulus(8'h48);
    apply_stimulus(8'h45);
    apply_stimulus(8'h4C);
    apply_stimulus(8'h4C);
    apply_stimulus(8'h4F);
    check_output("cursor_25", bus.cursor_xy, 8'h25);
    apply_stimulus(8'h0D);
    check_output("cr_cursor", bus.cursor_xy, 8'h20);
    apply_stimulus(8'h0A);
    check_output("lf_cursor", bus.cursor_xy, 8'h40);
    repeat (5) apply_stimulus(8'h0A);
    check_output("row7_cursor", bus.cursor_xy, 8'hE0);
    apply_stimulus(8'h0A);
    check_output("lf_wrap_cursor", bus.cursor_xy, 8'h00);
    probe("hello_E", 8'h21, 4'h9);

    apply_stimulus(8'h08);
    check_output("bs_wrap_cursor", bus.cursor_xy, 8'hFF);
    probe("bs_cell255", 8'hFF, 4'h2);
    apply_stimulus(8'h42);
    check_output("wrap_cursor", bus.cursor_xy, 8'h00);
    probe("cell255_B", 8'hFF, 4'h7);
    check_output("cell255_code", bus.font_addr[10:4], 7'h42);
    apply_stimulus(8'h08);
    check_output("bs_again_cursor", bus.cursor_xy, 8'hFF);
    probe("cell255_blank", 8'hFF, 4'h7);
    probe("cursor255_line15", 8'hFF, 4'hF);

    // Form feed with the writer holding the next code across the whole clear
    apply_stimulus(8'h51);
    apply_stimulus(8'h52);
    apply_stimulus(8'h0C);
    check_output("ff_cursor_hold", bus.cursor_xy, 8'h01);
    bus.wr_data  = 8'h5A;
    bus.wr_valid = 1'b1;
    wait_clear("ff_clear");
    tick();
    bus.wr_valid = 1'b0;
    model_write(8'h5A);
    check_output("ff_held_cursor", bus.cursor_xy, 8'h01);
    probe("ff_held_cell", 8'h00, 4'h4);
    probe("ff_cleared_cell", 8'hFF, 4'h4);

    // Reset in the middle of a clear restarts the full sequence
    apply_stimulus(8'h53);
    apply_stimulus(8'h0C);
    bus.char_xy   = 8'h10;
    bus.char_line = 4'h0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    check_output("midrst_pixels", bus.char_pixels, 8'h00);
    check_output("midrst_cursor", bus.cursor_xy, 8'h00);
    check_output("midrst_busy", bus.busy, 1);
    check_output("midrst_ready", bus.wr_ready, 0);
    rst = 1'b0;
    wait_clear("midrst_clear");
    probe("midrst_cell0", 8'h00, 4'h1);
    probe("midrst_cursor15", 8'h00, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
